sram_bank_arbiter: RTL and testbench
====================================

// Module: sram_bank_arbiter
// PURPOSE
//  Shares the NUM_SRAMS banks of multi_sram between NUM_REQ requesters (loader DMA, compute engine, writeback).
//  Each bank has its own round-robin arbiter. Requests to different banks are granted in the same cycle.
//  The SRAM command is registered. Read data returns to the winning requester with a fixed 2-cycle latency.
//  Sits directly in front of multi_sram and drives its en/we/addr/data_in buses.
// PARAMETERS
//  NUM_REQ        3                 number of requesters
//  NUM_SRAMS      from params.vh    number of banks
//  MAX_ADDR_WIDTH from params.vh    per-bank address width
//  DATA_WIDTH     64                write data width per bank
//  SRAM_WIDTH_O   from params.vh    read data width per bank
//  BANK_W         $clog2(NUM_SRAMS) bank select width
// PORTS
//  clk          in   1                          clock, all logic on posedge
//  rst          in   1                          synchronous, active-high reset
//  req_valid    in   NUM_REQ                    request valid per requester
//  req_ready    out  NUM_REQ                    request accepted this cycle (combinational from valid/bank/pointers)
//  req_we       in   NUM_REQ                    1 = write, 0 = read
//  req_bank     in   NUM_REQ*BANK_W             target bank
//  req_addr     in   NUM_REQ*MAX_ADDR_WIDTH     word address in bank
//  req_wdata    in   NUM_REQ*DATA_WIDTH         write data
//  rsp_valid    out  NUM_REQ                    read data valid, 1-cycle pulse
//  rsp_rdata    out  NUM_REQ*SRAM_WIDTH_O       read data
//  err_bank     out  NUM_REQ                    1-cycle pulse: accepted request had req_bank >= NUM_SRAMS
//  sram_en      out  8                          to multi_sram en
//  sram_we      out  8                          to multi_sram we
//  sram_addr    out  NUM_SRAMS*MAX_ADDR_WIDTH   to multi_sram addr
//  sram_wdata   out  NUM_SRAMS*DATA_WIDTH       to multi_sram data_in
//  sram_rdata   in   NUM_SRAMS*SRAM_WIDTH_O     from multi_sram data_out
// BEHAVIOUR
//  Handshake: a request transfers in cycle T when req_valid & req_ready are both high.
//   - Inputs must stay stable while valid is high and ready is low.
//   - Each requester targets exactly one bank per cycle.
//  Arbitration (per bank b):
//   - Candidates are requesters with valid and req_bank==b.
//   - The winner is the first candidate at or after ptr[b], searching upward and wrapping at NUM_REQ.
//   - On a grant, ptr[b] <= winner+1, wrapping to 0. ptr[b] holds when bank b has no grant.
//   - Losers see ready=0. Worst-case wait is NUM_REQ-1 grants to that bank.
//  Command register, updated at T+1 from the bank-b grant in T:
//   - sram_en[b]=1, sram_we[b]=req_we, sram_addr/sram_wdata slice b from the winner.
//   - With no grant in T: sram_en[b]=sram_we[b]=0; addr/wdata hold their previous value.
//   - Bits sram_en/sram_we[7:NUM_SRAMS] are always 0.
//  Read return:
//   - Per bank, a 2-stage shift tracks {read, requester id}: stage1 at T+1, stage2 at T+2.
//   - At T+2, rsp_valid[id]=1 and rsp_rdata slice id = sram_rdata slice b.
//   - A requester may have one read per cycle in flight, so responses return in request order.
//   - rsp_rdata holds its last value when rsp_valid=0.
//   - Writes produce no response.
//  Illegal bank (req_bank >= NUM_SRAMS):
//   - req_ready=1 immediately, with no SRAM access.
//   - err_bank pulses at T+1. The request does not consume any bank's round-robin slot.
//  Reset: when rst=1 at a posedge, the following are cleared to 0 at that edge:
//   - ptr[], sram_en, sram_we, sram_addr, sram_wdata, rsp_valid, rsp_rdata, err_bank, both tracking stages.
//   - req_ready is 0 while rst is high.
//   - In-flight reads are dropped: no rsp_valid is produced after reset, even for requests accepted in cycles T-1 and T.
// STRUCTURE
//  Shared package / params.vh:
//   - Add NUM_REQ, BANK_W, REQ_ID_W=$clog2(NUM_REQ).
//   - Reuse the existing NUM_SRAMS, MAX_ADDR_WIDTH, SRAM_WIDTH_O.
//  Sub-module rr_arbiter #(N):
//   - Ports: clk, rst, req[N], grant[N] one-hot, gnt_id, any_grant. Pointer held internally.
//   - Instantiated once per bank in a generate loop.
//   - Top level holds the request decode, command registers, tracking stages and response mux.
// TESTING
//  1. Single read, req0 bank2 addr 5, after writing 0xA5A5 there:
//     - sram_en[2]=1 at T+1; rsp_valid[0]=1 with rdata 0xA5A5 at T+2; nothing else asserted.
//  2. All 3 requesters valid on bank0 for 6 cycles:
//     - Grants go 0,1,2,0,1,2; exactly one ready bit per cycle.
//  3. req0->bank0, req1->bank1, req2->bank3 in the same cycle:
//     - All ready; sram_en=0b00001011 at T+1.
//  4. req1 reads bank4 back-to-back, addrs 0..3, holding 0x10..0x13:
//     - rsp_valid[1] high for 4 consecutive cycles with data 0x10,0x11,0x12,0x13.
//  5. req2 with req_bank=NUM_SRAMS:
//     - ready=1; err_bank[2] pulses at T+1; sram_en stays 0; no rsp_valid.
//  6. rst asserted the cycle after a read is accepted:
//     - No rsp_valid ever appears for that read; all outputs 0; next grant on that bank goes to req0.

Source files
------------

// File: rtl/sram_bank_arbiter_pkg.sv
// Shared parameters and types for the SRAM bank arbiter and its requester/SRAM bus.
package sram_bank_arbiter_pkg;
    localparam int NUM_REQ        = 3;
    localparam int NUM_SRAMS      = 6;
    localparam int MAX_ADDR_WIDTH = 8;
    localparam int DATA_WIDTH     = 64;
    localparam int SRAM_WIDTH_O   = 64;
    localparam int EN_W           = 8;
    localparam int BANK_W         = $clog2(NUM_SRAMS);
    localparam int REQ_ID_W       = $clog2(NUM_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    // Read-return tracking entry: a read for requester id is in flight on this bank.
    typedef struct packed {
        logic    rd;
        req_id_t id;
    } trk_t;

    function automatic logic bank_legal(input logic [BANK_W-1:0] bank);
        return {1'b0, bank} < (BANK_W+1)'(NUM_SRAMS);
    endfunction
endpackage

// File: rtl/sram_bank_arbiter_if.sv
// Requester handshake plus multi_sram command/data bus seen by the bank arbiter.
interface sram_bank_arbiter_if;
    import sram_bank_arbiter_pkg::*;

    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ-1:0]                       req_ready;
    logic [NUM_REQ-1:0]                       req_we;
    logic [NUM_REQ-1:0][BANK_W-1:0]           req_bank;
    logic [NUM_REQ-1:0][MAX_ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_wdata;
    logic [NUM_REQ-1:0]                       rsp_valid;
    logic [NUM_REQ-1:0][SRAM_WIDTH_O-1:0]     rsp_rdata;
    logic [NUM_REQ-1:0]                       err_bank;

    logic [EN_W-1:0]                          sram_en;
    logic [EN_W-1:0]                          sram_we;
    logic [NUM_SRAMS-1:0][MAX_ADDR_WIDTH-1:0] sram_addr;
    logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0]     sram_wdata;
    logic [NUM_SRAMS-1:0][SRAM_WIDTH_O-1:0]   sram_rdata;

    modport slave (
        input  req_valid, req_we, req_bank, req_addr, req_wdata, sram_rdata,
        output req_ready, rsp_valid, rsp_rdata, err_bank,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output req_valid, req_we, req_bank, req_addr, req_wdata, sram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, err_bank,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_bank_arbiter_rr.sv
// Round-robin arbiter: first requester at or after the pointer wins, pointer then moves past the winner.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gnt_id,
    output logic          any_grant
);
    logic [IW-1:0] ptr;

    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        gnt_id    = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant[idx] = 1'b1;
                gnt_id     = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            ptr <= '0;
        else if (any_grant) ptr <= (int'(gnt_id) == N-1) ? '0 : gnt_id + 1'b1;
    end
endmodule

// File: rtl/sram_bank_arbiter.sv
// Per-bank round-robin arbitration in front of multi_sram: registered command, fixed 2-cycle read return.
module sram_bank_arbiter
    import sram_bank_arbiter_pkg::*;
(
    input logic                clk,
    input logic                rst,
    sram_bank_arbiter_if.slave bus
);
    logic [NUM_SRAMS-1:0][NUM_REQ-1:0]        bank_req;
    logic [NUM_SRAMS-1:0][NUM_REQ-1:0]        bank_gnt;
    logic [NUM_SRAMS-1:0]                     bank_any;
    req_id_t [NUM_SRAMS-1:0]                  bank_id;
    logic [NUM_REQ-1:0]                       legal;

    logic [NUM_SRAMS-1:0]                     en_q;
    logic [NUM_SRAMS-1:0]                     we_q;
    logic [NUM_SRAMS-1:0][MAX_ADDR_WIDTH-1:0] addr_q;
    logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0]     wdata_q;
    trk_t [NUM_SRAMS-1:0]                     trk1_q;
    trk_t [NUM_SRAMS-1:0]                     trk2_q;
    logic [NUM_REQ-1:0]                       err_q;
    logic [NUM_REQ-1:0]                       rsp_v;
    logic [NUM_REQ-1:0][SRAM_WIDTH_O-1:0]     rsp_d;
    logic [NUM_REQ-1:0][SRAM_WIDTH_O-1:0]     hold_q;

    always_comb begin
        legal    = '0;
        bank_req = '0;
        for (int i = 0; i < NUM_REQ; i++) legal[i] = bank_legal(bus.req_bank[i]);
        for (int b = 0; b < NUM_SRAMS; b++)
            for (int i = 0; i < NUM_REQ; i++)
                bank_req[b][i] = !rst && bus.req_valid[i] && legal[i] &&
                                 (bus.req_bank[i] == BANK_W'(b));
    end

    for (genvar b = 0; b < NUM_SRAMS; b++) begin : g_bank
        rr_arbiter #(.N(NUM_REQ), .IW(REQ_ID_W)) u_arb (
            .clk       (clk),
            .rst       (rst),
            .req       (bank_req[b]),
            .grant     (bank_gnt[b]),
            .gnt_id    (bank_id[b]),
            .any_grant (bank_any[b])
        );
    end

    // Illegal banks are acknowledged at once so a bad requester never stalls.
    always_comb begin
        bus.req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst && bus.req_valid[i] && !legal[i]) bus.req_ready[i] = 1'b1;
            for (int b = 0; b < NUM_SRAMS; b++)
                if (bank_gnt[b][i]) bus.req_ready[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            trk1_q  <= '0;
            trk2_q  <= '0;
            err_q   <= '0;
        end else begin
            for (int b = 0; b < NUM_SRAMS; b++) begin
                en_q[b]   <= bank_any[b];
                we_q[b]   <= bank_any[b] && bus.req_we[bank_id[b]];
                if (bank_any[b]) begin
                    addr_q[b]  <= bus.req_addr[bank_id[b]];
                    wdata_q[b] <= bus.req_wdata[bank_id[b]];
                end
                trk1_q[b] <= trk_t'{rd: bank_any[b] && !bus.req_we[bank_id[b]], id: bank_id[b]};
            end
            trk2_q <= trk1_q;
            for (int i = 0; i < NUM_REQ; i++)
                err_q[i] <= bus.req_valid[i] && !legal[i];
        end
    end

    // SRAM data arrives in the same cycle as stage 2, so it is steered through
    // combinationally; hold_q keeps the last value visible between responses.
    always_comb begin
        rsp_v = '0;
        rsp_d = hold_q;
        for (int b = 0; b < NUM_SRAMS; b++)
            if (trk2_q[b].rd) begin
                rsp_v[trk2_q[b].id] = 1'b1;
                rsp_d[trk2_q[b].id] = bus.sram_rdata[b];
            end
    end

    always_ff @(posedge clk) begin
        if (rst) hold_q <= '0;
        else     hold_q <= rsp_d;
    end

    assign bus.rsp_valid  = rsp_v;
    assign bus.rsp_rdata  = rsp_d;
    assign bus.err_bank   = err_q;
    assign bus.sram_en    = EN_W'(en_q);
    assign bus.sram_we    = EN_W'(we_q);
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Directed plus randomized bench for sram_bank_arbiter, checked against a cycle-slot reference model.
module tb_sram_bank_arbiter;
    import sram_bank_arbiter_pkg::*;

    localparam int AW    = MAX_ADDR_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_bank_arbiter_if bus();
    sram_bank_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    // multi_sram stand-in: synchronous read, data visible the cycle after the command
    logic [SRAM_WIDTH_O-1:0] mem [NUM_SRAMS*DEPTH] = '{default: '0};
    logic [NUM_SRAMS-1:0][SRAM_WIDTH_O-1:0] dout = '0;
    assign bus.sram_rdata = dout;
    always @(posedge clk) begin
        for (int b = 0; b < NUM_SRAMS; b++)
            if (bus.sram_en[b]) begin
                if (bus.sram_we[b]) mem[b*DEPTH + int'(bus.sram_addr[b])] <= bus.sram_wdata[b];
                else                dout[b] <= mem[b*DEPTH + int'(bus.sram_addr[b])];
            end
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int ptr_m [NUM_SRAMS];
    logic [NUM_SRAMS-1:0]                 e_en [4];
    logic [NUM_SRAMS-1:0]                 e_we [4];
    logic [NUM_REQ-1:0]                   e_err [4];
    logic [NUM_REQ-1:0]                   e_rv [4];
    logic [SRAM_WIDTH_O-1:0]              e_rd [4][NUM_REQ];
    logic [NUM_SRAMS-1:0][AW-1:0]         m_addr;
    logic [NUM_SRAMS-1:0][DATA_WIDTH-1:0] m_wd;
    logic [NUM_REQ-1:0][SRAM_WIDTH_O-1:0] m_rd;
    logic [NUM_REQ-1:0]                   acc;
    logic [SRAM_WIDTH_O-1:0] ref_mem [NUM_SRAMS*DEPTH] = '{default: '0};

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic clear_slot(input int s);
        e_en[s] = '0; e_we[s] = '0; e_err[s] = '0; e_rv[s] = '0;
        for (int r = 0; r < NUM_REQ; r++) e_rd[s][r] = '0;
    endtask

    task automatic clear_model();
        for (int s = 0; s < 4; s++) clear_slot(s);
        for (int b = 0; b < NUM_SRAMS; b++) ptr_m[b] = 0;
        m_addr = '0; m_wd = '0; m_rd = '0;
    endtask

    task automatic drv(input int r, input bit v, input bit we, input int bank, input int addr,
                       input logic [DATA_WIDTH-1:0] wd);
        bus.req_valid[r] = v;
        bus.req_we[r]    = we;
        bus.req_bank[r]  = BANK_W'(bank);
        bus.req_addr[r]  = AW'(addr);
        bus.req_wdata[r] = wd;
    endtask

    task automatic idle();
        bus.req_valid = '0;
        bus.req_we    = '0;
    endtask

    // One clock: predict acceptances from the current inputs, then check the registered outputs.
    task automatic step();
        int n1, n2, w, r, a, s;
        #1;
        acc = '0;
        n1  = (cyc + 1) % 4;
        n2  = (cyc + 2) % 4;
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (bus.req_valid[i] && int'(bus.req_bank[i]) >= NUM_SRAMS) begin
                    acc[i]        = 1'b1;
                    e_err[n1][i]  = 1'b1;
                end
            for (int b = 0; b < NUM_SRAMS; b++) begin
                w = -1;
                for (int k = 0; k < NUM_REQ && w < 0; k++) begin
                    r = (ptr_m[b] + k) % NUM_REQ;
                    if (bus.req_valid[r] && int'(bus.req_bank[r]) == b) w = r;
                end
                if (w >= 0) begin
                    acc[w]      = 1'b1;
                    ptr_m[b]    = (w + 1) % NUM_REQ;
                    a           = b*DEPTH + int'(bus.req_addr[w]);
                    e_en[n1][b] = 1'b1;
                    e_we[n1][b] = bus.req_we[w];
                    m_addr[b]   = bus.req_addr[w];
                    m_wd[b]     = bus.req_wdata[w];
                    if (bus.req_we[w]) ref_mem[a] = bus.req_wdata[w];
                    else begin
                        e_rv[n2][w] = 1'b1;
                        e_rd[n2][w] = ref_mem[a];
                    end
                end
            end
        end
        chk("req_ready", 512'(bus.req_ready), 512'(acc));
        if (rst) clear_model();
        @(posedge clk);
        cyc++;
        #1;
        s = cyc % 4;
        chk("sram_en",    512'(bus.sram_en),    512'(e_en[s]));
        chk("sram_we",    512'(bus.sram_we),    512'(e_we[s]));
        chk("sram_addr",  512'(bus.sram_addr),  512'(m_addr));
        chk("sram_wdata", 512'(bus.sram_wdata), 512'(m_wd));
        chk("err_bank",   512'(bus.err_bank),   512'(e_err[s]));
        chk("rsp_valid",  512'(bus.rsp_valid),  512'(e_rv[s]));
        for (int i = 0; i < NUM_REQ; i++) if (e_rv[s][i]) m_rd[i] = e_rd[s][i];
        chk("rsp_rdata",  512'(bus.rsp_rdata),  512'(m_rd));
        clear_slot(s);
    endtask

    initial begin
        clear_model();
        acc = '0;
        for (int r = 0; r < NUM_REQ; r++) drv(r, 1'b0, 1'b0, 0, 0, '0);

        // reset state
        rst = 1'b1; step(); step(); rst = 1'b0;
        chk("rst_en",    512'(bus.sram_en),   512'(0));
        chk("rst_rv",    512'(bus.rsp_valid), 512'(0));
        chk("rst_rdata", 512'(bus.rsp_rdata), 512'(0));
        chk("rst_err",   512'(bus.err_bank),  512'(0));

        // all requesters on bank0: strict rotation from a fresh pointer
        for (int r = 0; r < NUM_REQ; r++) drv(r, 1'b1, 1'b0, 0, r, '0);
        for (int k = 0; k < 6; k++) begin
            #1 chk("t2_gnt", 512'(bus.req_ready), 512'(1 << (k % NUM_REQ)));
            step();
        end
        idle(); step(); step(); step();

        // write 0xA5A5 to bank2 addr5, then read it back on req0
        drv(0, 1'b1, 1'b1, 2, 5, 64'hA5A5); step(); idle(); step();
        drv(0, 1'b1, 1'b0, 2, 5, '0); step(); idle();
        chk("t1_en", 512'(bus.sram_en), 512'(8'h04));
        chk("t1_we", 512'(bus.sram_we), 512'(0));
        step();
        chk("t1_rv",    512'(bus.rsp_valid),    512'(3'b001));
        chk("t1_rdata", 512'(bus.rsp_rdata[0]), 512'(64'hA5A5));
        chk("t1_err",   512'(bus.err_bank),     512'(0));
        step();

        // three different banks granted together
        drv(0, 1'b1, 1'b0, 0, 1, '0); drv(1, 1'b1, 1'b0, 1, 2, '0); drv(2, 1'b1, 1'b0, 3, 3, '0);
        #1 chk("t3_rdy", 512'(bus.req_ready), 512'(3'b111));
        step(); idle();
        chk("t3_en", 512'(bus.sram_en), 512'(8'b0000_1011));
        step(); step();

        // back-to-back reads on bank4
        for (int k = 0; k < 4; k++) begin drv(1, 1'b1, 1'b1, 4, k, 64'(16 + k)); step(); end
        idle(); step();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) drv(1, 1'b1, 1'b0, 4, k, '0); else idle();
            step();
            if (k >= 1 && k <= 4) begin
                chk("t4_rv",    512'(bus.rsp_valid[1]), 512'(1));
                chk("t4_rdata", 512'(bus.rsp_rdata[1]), 512'(16 + k - 1));
            end
        end

        // illegal bank
        drv(2, 1'b1, 1'b0, NUM_SRAMS, 0, '0);
        #1 chk("t5_rdy", 512'(bus.req_ready[2]), 512'(1));
        step(); idle();
        chk("t5_err", 512'(bus.err_bank), 512'(3'b100));
        chk("t5_en",  512'(bus.sram_en),  512'(0));
        step();
        chk("t5_err_off", 512'(bus.err_bank),  512'(0));
        chk("t5_rv",      512'(bus.rsp_valid), 512'(0));
        step();
        chk("t5_rv2", 512'(bus.rsp_valid), 512'(0));

        // reset right after a read is accepted drops it and rewinds the pointer
        drv(1, 1'b1, 1'b0, 3, 7, '0); step(); idle();
        rst = 1'b1; step(); rst = 1'b0;
        chk("t6_en",    512'(bus.sram_en),   512'(0));
        chk("t6_rv",    512'(bus.rsp_valid), 512'(0));
        chk("t6_rdata", 512'(bus.rsp_rdata), 512'(0));
        chk("t6_addr",  512'(bus.sram_addr), 512'(0));
        step();
        chk("t6_rv2", 512'(bus.rsp_valid), 512'(0));
        for (int r = 0; r < NUM_REQ; r++) drv(r, 1'b1, 1'b0, 3, r, '0);
        #1 chk("t6_gnt", 512'(bus.req_ready), 512'(3'b001));
        step(); idle(); step(); step(); step();

        // randomized traffic; an unaccepted request holds its inputs
        for (int c = 0; c < 1500; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int r = 0; r < NUM_REQ; r++)
                if (!bus.req_valid[r] || acc[r])
                    drv(r, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                        ($urandom_range(0, 9) == 0) ? int'($urandom_range(NUM_SRAMS, (1 << BANK_W) - 1)) :
                        ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1)) :
                                                      int'($urandom_range(0, NUM_SRAMS - 1)),
                        int'($urandom_range(0, 7)), {$urandom, $urandom});
            step();
        end
        rst = 1'b0; idle(); step(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
